// File: rtl/button_debouncer_scen_pkg.sv
// Shared definitions for the push-button debouncer: one-hot state
// encodings and the hold-time multiplier applied to the debounce period.
package button_debouncer_scen_pkg;

    // Hold time before auto-repeat is this many debounce periods.
    // The counter width in the top (N_DC+2) relies on this being 4.
    localparam int HOLD_MULT = 4;

    typedef enum logic [5:0] {
        ST_INI  = 6'b000001,
        ST_WQ   = 6'b000010,
        ST_SCEN = 6'b000100,
        ST_WH   = 6'b001000,
        ST_MCEN = 6'b010000,
        ST_CCR  = 6'b100000
    } db_state_e;

endpackage

// File: rtl/button_debouncer_scen_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module button_debouncer_scen_sync_2ff (
    input  logic board_clk,
    input  logic Reset,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; second flop gives it a full cycle to settle.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debouncer_scen.sv
// Push-button debouncer with single-shot, multi-shot and continuous enables.
//
// state   | meaning
// --------+---------------------------------------------------------------
// INI     | idle, button released
// WQ      | button seen high, waiting DB_CYC clocks for it to stay quiet
// SCEN_ST | one-clock press pulse on SCEN/MCEN/CCEN
// WH      | button held, counting toward HOLD_CYC before auto-repeat
// MCEN_ST | auto-repeat: CCEN high, MCEN pulses once per DB_CYC clocks
// CCR     | button seen low, waiting DB_CYC clocks to confirm release
module button_debouncer_scen
    import button_debouncer_scen_pkg::*;
#(
    parameter int N_DC = 20
) (
    input  logic board_clk,
    input  logic Reset,
    input  logic PB,
    output logic DPB,
    output logic SCEN,
    output logic MCEN,
    output logic CCEN
);

    localparam int CW       = N_DC + 2;
    localparam int DB_CYC   = 1 << N_DC;
    localparam int HOLD_CYC = HOLD_MULT * DB_CYC;

    localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);

    db_state_e         state;
    db_state_e         state_nxt;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;
    logic [CW-1:0]     cnt_inc;
    logic [N_DC-1:0]   cnt_lo_inc;
    logic              pb_s;

    button_debouncer_scen_sync_2ff u_sync_2ff (
        .board_clk (board_clk),
        .Reset     (Reset),
        .d         (PB),
        .q         (pb_s)
    );

    assign cnt_inc    = cnt + CW'(1);
    assign cnt_lo_inc = cnt[N_DC-1:0] + N_DC'(1);

    // State and interval counter registers.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            state <= ST_INI;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; the counter restarts from zero on every state entry.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_inc;
        case (state)
            ST_INI: begin
                cnt_nxt = '0;
                if (pb_s) state_nxt = ST_WQ;
            end
            ST_WQ: begin
                if (!pb_s)               state_nxt = ST_INI;
                else if (cnt == DB_LAST) state_nxt = ST_SCEN;
            end
            ST_SCEN: begin
                state_nxt = ST_WH;
            end
            ST_WH: begin
                if (!pb_s)                 state_nxt = ST_CCR;
                else if (cnt == HOLD_LAST) state_nxt = ST_MCEN;
            end
            ST_MCEN: begin
                // Only the low N_DC bits run here so the repeat phase wraps freely.
                cnt_nxt = {cnt[CW-1:N_DC], cnt_lo_inc};
                if (!pb_s) state_nxt = ST_CCR;
            end
            ST_CCR: begin
                if (pb_s)                state_nxt = ST_WH;
                else if (cnt == DB_LAST) state_nxt = ST_INI;
            end
            default: begin
                state_nxt = ST_INI;
            end
        endcase
        if (state_nxt != state) cnt_nxt = '0;
    end

    // Moore output decode from the registered state only.
    always_comb begin
        DPB  = 1'b0;
        SCEN = 1'b0;
        MCEN = 1'b0;
        CCEN = 1'b0;
        case (state)
            ST_SCEN: begin
                DPB  = 1'b1;
                SCEN = 1'b1;
                MCEN = 1'b1;
                CCEN = 1'b1;
            end
            ST_WH, ST_CCR: begin
                DPB = 1'b1;
            end
            ST_MCEN: begin
                DPB  = 1'b1;
                CCEN = 1'b1;
                MCEN = &cnt[N_DC-1:0];
            end
            default: begin
                DPB = 1'b0;
            end
        endcase
    end

endmodule
